// File: rtl/instr_queue.sv
// Circular instruction FIFO between fetch and decode, with single-cycle redirect flush.
// Optional same-cycle fetch->decode bypass on an empty queue: define INSTR_QUEUE_BYPASS_EN.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          f_valid_i,
    input  logic [31:0]   f_pc_i,
    input  logic [31:0]   f_instr_i,
    input  logic          f_fault_i,
    output logic          f_ready_o,
    output logic          d_valid_o,
    output logic [31:0]   d_pc_o,
    output logic [31:0]   d_instr_o,
    output logic          d_fault_o,
    input  logic          d_ready_i,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic          fault_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full, empty, bypass;
    logic enq_fire, deq_fire, store, pop;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
`ifdef INSTR_QUEUE_BYPASS_EN
        bypass = empty && f_valid_i && !flush_i && !rst;
`else
        bypass = 1'b0;
`endif
        f_ready_o = !rst && !flush_i && !full;
        d_valid_o = !rst && !flush_i && (!empty || bypass);

        d_pc_o    = '0;
        d_instr_o = '0;
        d_fault_o = 1'b0;
        if (!rst) begin
`ifdef INSTR_QUEUE_BYPASS_EN
            if (bypass) begin
                d_pc_o    = f_pc_i;
                d_instr_o = f_instr_i;
                d_fault_o = f_fault_i;
            end else begin
                d_pc_o    = pc_q[rd_ptr_q];
                d_instr_o = instr_q[rd_ptr_q];
                d_fault_o = fault_q[rd_ptr_q];
            end
`else
            d_pc_o    = pc_q[rd_ptr_q];
            d_instr_o = instr_q[rd_ptr_q];
            d_fault_o = fault_q[rd_ptr_q];
`endif
        end

        enq_fire = f_valid_i && f_ready_o;
        deq_fire = d_valid_o && d_ready_i;
        // A bypassed entry consumed by decode never touches storage or pointers.
        store = enq_fire && !(bypass && d_ready_i);
        pop   = deq_fire && !bypass;

        wr_ptr_d = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (store && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !store)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Per-entry storage so reset can clear every slot in one edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    pc_q[gi]    <= '0;
                    instr_q[gi] <= '0;
                    fault_q[gi] <= 1'b0;
                end else if (store && (wr_ptr_q == AW'(gi))) begin
                    pc_q[gi]    <= f_pc_i;
                    instr_q[gi] <= f_instr_i;
                    fault_q[gi] <= f_fault_i;
                end
            end
        end
    endgenerate

    assign count_o = count_q;
endmodule
